// File: rtl/adder_issue_ctrl.sv
// adder_issue_ctrl: issue controller for a 4-stage pipelined 32-bit adder.
// It holds an operand FIFO and a result FIFO, and issues operations under a
// credit rule so the result FIFO can never overflow. flush_req discards all
// queued and in-flight work.
// Optional feature: define ISSUE_STATS_EN to add the issue_cnt and retire_cnt
// counters.
module adder_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_c,
  input  logic        flush_req,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  output logic [3:0]  add_halt,
  output logic [3:0]  add_refresh,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_cout,
  output logic [2:0]  opq_count
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] retire_cnt
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state_q;
  state_t      state_d;

  logic [64:0] opq_mem [4];
  logic [1:0]  opq_wr;
  logic [1:0]  opq_rd;
  logic [2:0]  opq_cnt;

  logic [32:0] rq_mem [4];
  logic [1:0]  rq_wr;
  logic [1:0]  rq_rd;
  logic [2:0]  rq_cnt;

  logic [3:0]  vld;
  logic [2:0]  inflight;
  logic        run;
  logic        push;
  logic        issue;
  logic        pop;
  logic        clear;

  assign run      = (state_q == RUN);
  assign inflight = {2'b00, vld[0]} + {2'b00, vld[1]} + {2'b00, vld[2]} + {2'b00, vld[3]};
  assign issue    = run && (opq_cnt != 3'd0) &&
                    (({1'b0, rq_cnt} + {1'b0, inflight}) < 4'd4);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign clear    = rst || flush_req || !run;

  assign opq_count = opq_cnt;
  assign add_halt  = 4'b0000;
  assign add_a     = (opq_cnt != 3'd0) ? opq_mem[opq_rd][31:0]  : 32'd0;
  assign add_b     = (opq_cnt != 3'd0) ? opq_mem[opq_rd][63:32] : 32'd0;
  assign add_cin   = (opq_cnt != 3'd0) ? opq_mem[opq_rd][64]    : 1'b0;
  assign out_sum   = out_valid ? rq_mem[rq_rd][31:0] : 32'd0;
  assign out_cout  = out_valid ? rq_mem[rq_rd][32]   : 1'b0;

  // State register: reset returns to RUN.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state: flush_req enters or holds FLUSH, otherwise FLUSH lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = flush_req ? FLUSH : RUN;
      FLUSH:   state_d = flush_req ? FLUSH : RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs that depend on the state: handshakes are blocked and the adder is refreshed outside RUN.
  always_comb begin
    in_ready    = !rst && run && (opq_cnt < 3'd4);
    out_valid   = !rst && run && (rq_cnt != 3'd0);
    add_refresh = (rst || !run) ? 4'b1111 : 4'b0000;
  end

  // Operand FIFO storage; entries written while flushing are unreachable because the pointers clear.
  always_ff @(posedge clk) begin
    if (push) opq_mem[opq_wr] <= {in_c, in_b, in_a};
  end

  // Operand FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (clear) begin
      opq_wr  <= 2'd0;
      opq_rd  <= 2'd0;
      opq_cnt <= 3'd0;
    end else begin
      if (push)  opq_wr <= opq_wr + 2'd1;
      if (issue) opq_rd <= opq_rd + 2'd1;
      opq_cnt <= opq_cnt + {2'b00, push} - {2'b00, issue};
    end
  end

  // In-flight tracker: bit 3 marks the adder output valid in that cycle.
  always_ff @(posedge clk) begin
    if (clear) vld <= 4'd0;
    else       vld <= {vld[2:0], issue};
  end

  // Result FIFO storage captures the adder output that vld[3] marks.
  always_ff @(posedge clk) begin
    if (vld[3]) rq_mem[rq_wr] <= {add_cout, add_sum};
  end

  // Result FIFO pointers and occupancy; simultaneous push and pop are both honoured.
  always_ff @(posedge clk) begin
    if (clear) begin
      rq_wr  <= 2'd0;
      rq_rd  <= 2'd0;
      rq_cnt <= 3'd0;
    end else begin
      if (vld[3]) rq_wr <= rq_wr + 2'd1;
      if (pop)    rq_rd <= rq_rd + 2'd1;
      rq_cnt <= rq_cnt + {2'b00, vld[3]} - {2'b00, pop};
    end
  end

`ifdef ISSUE_STATS_EN
  // Wrapping activity counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt  <= 16'd0;
      retire_cnt <= 16'd0;
    end else begin
      if (issue && !flush_req) issue_cnt  <= issue_cnt + 16'd1;
      if (pop && !flush_req)   retire_cnt <= retire_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/adder_issue_ctrl.md
ADDER_ISSUE_CTRL -- requirements
Module: adder_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, 32), in_b (input, 32) and in_c (input, 1): the operand push handshake.
REQ-004 SHALL have port flush_req, input, 1 bit: discards all queued and in-flight work.
REQ-005 SHALL have ports add_a (output, 32), add_b (output, 32), add_cin (output, 1), add_halt (output, 4) and add_refresh (output, 4): these drive the 4-stage pipelined adder.
REQ-006 SHALL have ports add_sum (input, 32) and add_cout (input, 1): the adder stage-4 outputs.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_sum (output, 32) and out_cout (output, 1): the result pop handshake.
REQ-008 SHALL have port opq_count, output, 3 bits: operand queue occupancy, range 0..4.

Function
REQ-009 SHALL hold an operand queue (FIFO) of 4 entries, each {in_c, in_b, in_a}.
  - Push condition: in_valid && in_ready.
  - in_ready = (opq_count<4) && state==RUN.
  - No same-cycle pass-through at full.
REQ-010 SHALL drive add_a/add_b/add_cin combinationally from the queue head; when the queue is empty, these outputs are 0.
REQ-011 SHALL issue in any cycle that meets all of the following:
  - state==RUN;
  - queue non-empty;
  - rq_count + popcount(vld) < 4, using registered values.
  Issuing pops the queue head.
REQ-012 SHALL keep a 4-bit in-flight shift register vld, with update vld <= {vld[2:0], issue} every cycle.
  - vld[3]==1 marks add_sum/add_cout as valid in that cycle.
REQ-013 SHALL capture {add_cout, add_sum} into a 4-entry result FIFO at the clock edge that ends any cycle with vld[3]==1.
REQ-014 SHALL present the result FIFO head on out_valid/out_sum/out_cout.
  - Pop condition: out_valid && out_ready.
  - Push and pop in the same cycle are both honoured.
REQ-015 SHALL, through the credit rule in REQ-011, prevent result FIFO overflow; add_halt SHALL be held at 4'b0000 at all times (the adder is never stalled).
REQ-016 SHALL have end-to-end latency as follows:
  - Operand pushed in cycle 0 with both queues empty → issued in cycle 1 → vld[3] high in cycle 5 → out_valid high in cycle 6.
REQ-017 SHALL implement a state machine with states RUN and FLUSH.
  - RUN→FLUSH: flush_req sampled high.
  - FLUSH→RUN: after exactly one cycle.
  - A flush_req held high keeps the block in FLUSH.
REQ-018 SHALL behave as follows in FLUSH:
  - add_refresh = 4'b1111;
  - operand queue, result FIFO and vld are cleared;
  - no push, issue or pop occurs;
  - in_ready = 0 and out_valid = 0.
REQ-019 SHALL give flush_req priority over a push, issue or pop that occurs in the same cycle; a transaction that completes in the cycle flush_req is sampled is discarded.
REQ-020 SHALL drive add_refresh = 4'b0000 in RUN.
REQ-021 SHALL wrap the queue pointers modulo 4 and derive full/empty from 3-bit counts.

Reset
REQ-022 SHALL, with rst high at an edge, set:
  - state = RUN;
  - both FIFOs empty and vld = 0;
  - in_ready = 0 during the reset cycle;
  - out_valid = 0, out_sum = 0, out_cout = 0;
  - add_a = add_b = 0, add_cin = 0;
  - add_halt = 0, add_refresh = 4'b1111 while rst is high.
REQ-023 SHALL give rst priority over flush_req and all handshakes; reset in mid-operation drops every queued and in-flight entry.

Configuration
REQ-024 SHALL, with ISSUE_STATS_EN defined, add ports issue_cnt and retire_cnt (both output, 16 bits, wrapping).
  - issue_cnt increments per issue.
  - retire_cnt increments per result pop.
  - Both are zeroed by rst only; flush does not clear them.
REQ-025 SHALL, without ISSUE_STATS_EN, omit these ports and counters; all other behaviour is identical.

Verification
REQ-026 Single op: push a=0x000000FF, b=0x00000001, c=0 in cycle 0, out_ready=1 → out_valid in cycle 6 with out_sum=0x00000100, out_cout=0.
REQ-027 Carry out: push a=0xFFFFFFFF, b=0x00000000, c=1 → out_sum=0x00000000, out_cout=1.
REQ-028 Backpressure: out_ready=0, push 8 ops → at most 4 issued, opq_count reaches 4, in_ready=0. Then raise out_ready → all 8 results emerge in order, none lost.
REQ-029 Flush mid-stream: 3 ops in flight plus 2 queued, pulse flush_req → one FLUSH cycle with add_refresh=4'b1111. Afterwards opq_count=0, out_valid stays 0, and the next push returns a correct result 6 cycles later.
REQ-030 Reset mid-stream: rst high for one cycle with full queues → all outputs take reset values, no stale result appears. With ISSUE_STATS_EN defined, issue_cnt=0 after reset.
